// File: rtl/eight_bit_divider_seq.sv
// +-----------------------------------------------------------------------------+
// | Module      : eight_bit_divider_seq                                         |
// | Description : Sequential signed restoring divider, one quotient bit/cycle.  |
// |               Optional macro DIV_ZERO_FAST_EN: zero operands finish at T0.  |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module eight_bit_divider_seq #(
  parameter int DIVIDEND_W = 17,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  ovf,
  output logic                  dbz,
  output logic                  busy
);

  localparam int c_cnt_w = $clog2(DIVIDEND_W);
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                  r_neg_q;
  logic                  r_neg_r;
  logic [DIVIDEND_W-1:0] r_quo_mag;
  logic [DIVISOR_W-1:0]  r_dvs_mag;
  logic [DIVISOR_W-1:0]  r_prem;
  logic [c_cnt_w-1:0]    r_cnt;

  logic [DIVIDEND_W-1:0] w_dvd_mag;
  logic [DIVISOR_W-1:0]  w_dvs_mag;
  logic [DIVISOR_W:0]    w_shift;
  logic                  w_sub_ok;
  logic [DIVISOR_W-1:0]  w_diff;
  logic [DIVIDEND_W-1:0] w_quo_s;
  logic [DIVISOR_W-1:0]  w_rem_s;
  logic                  w_fast;

  assign w_dvd_mag = dividend[DIVIDEND_W-1] ? -dividend : dividend;
  assign w_dvs_mag = divisor[DIVISOR_W-1]   ? -divisor  : divisor;

  // The stored remainder is always below |divisor| <= 128, so only the shifted
  // value needs the extra bit; the difference fits in DIVISOR_W bits.
  assign w_shift  = {r_prem, r_quo_mag[DIVIDEND_W-1]};
  assign w_sub_ok = (w_shift >= {1'b0, r_dvs_mag});
  assign w_diff   = w_shift[DIVISOR_W-1:0] - r_dvs_mag;

  assign w_quo_s = r_neg_q ? -r_quo_mag : r_quo_mag;
  assign w_rem_s = r_neg_r ? -r_prem    : r_prem;

`ifdef DIV_ZERO_FAST_EN
  assign w_fast = (divisor == '0) || (dividend == '0);
`else
  assign w_fast = 1'b0;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == CALC) || (r_state == FIX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (in_valid) w_next = w_fast ? DONE : CALC;
      CALC: if (r_cnt == '0) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_quo_mag <= '0;
      r_dvs_mag <= '0;
      r_prem    <= '0;
      r_cnt     <= '0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_neg_q   <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
            r_neg_r   <= dividend[DIVIDEND_W-1];
            r_quo_mag <= w_dvd_mag;
            r_dvs_mag <= w_dvs_mag;
            r_prem    <= '0;
            r_cnt     <= c_cnt_init;
            if (w_fast) begin
              quotient  <= (divisor == '0) ? '1 : '0;
              remainder <= '0;
              ovf       <= 1'b0;
              dbz       <= (divisor == '0);
            end
          end
        end
        CALC: begin
          // Quotient bits shift into the vacated low end of the dividend register.
          r_prem    <= w_sub_ok ? w_diff : w_shift[DIVISOR_W-1:0];
          r_quo_mag <= {r_quo_mag[DIVIDEND_W-2:0], w_sub_ok};
          r_cnt     <= r_cnt - 1'b1;
        end
        FIX: begin
          if (r_dvs_mag == '0) begin
            quotient  <= '1;
            remainder <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b1;
          end else begin
            quotient  <= w_quo_s;
            remainder <= w_rem_s;
            // A magnitude of 2^(W-1) is only representable when negated.
            ovf       <= r_quo_mag[DIVIDEND_W-1] & ~r_neg_q;
            dbz       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_eight_bit_divider_seq.sv
// +-----------------------------------------------------------------------------+
// | Module      : tb_eight_bit_divider_seq                                      |
// | Description : Self-checking bench for eight_bit_divider_seq.                |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_eight_bit_divider_seq;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [16:0] dividend  = '0;
  logic [7:0]  divisor   = '0;
  logic        in_ready;
  logic        out_valid;
  logic [16:0] quotient;
  logic [7:0]  remainder;
  logic        ovf;
  logic        dbz;
  logic        busy;

  eight_bit_divider_seq #(.DIVIDEND_W(17), .DIVISOR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .ovf       (ovf),
    .dbz       (dbz),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] e_q;
  logic [7:0]  e_r;
  logic        e_ovf;
  logic        e_dbz;
  int          e_lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer division truncates toward zero, remainder follows dividend.
  task automatic model(input int a, input int b);
    int qi;
    int ri;
    if (b == 0) begin
      e_q = 17'h1FFFF; e_r = 8'h00; e_ovf = 1'b0; e_dbz = 1'b1;
    end else begin
      qi = a / b;
      ri = a % b;
      e_q   = qi[16:0];
      e_r   = ri[7:0];
      e_ovf = (a == -65536) && (b == -1);
      e_dbz = 1'b0;
    end
`ifdef DIV_ZERO_FAST_EN
    e_lat = (a == 0 || b == 0) ? 0 : 18;
`else
    e_lat = 18;
`endif
  endtask

  task automatic wait_result(input int a, input int b, input string tag);
    int lat = 0;
    model(a, b);
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"},      lat,       e_lat);
    check({tag, ".quot"},     quotient,  {15'd0, e_q});
    check({tag, ".rem"},      remainder, {24'd0, e_r});
    check({tag, ".ovf"},      ovf,       {31'd0, e_ovf});
    check({tag, ".dbz"},      dbz,       {31'd0, e_dbz});
    check({tag, ".busy"},     busy,      0);
    check({tag, ".in_ready"}, in_ready,  0);
  endtask

  task automatic issue(input int a, input int b, input string tag);
    int w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check({tag, ".idle"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = a[16:0];
    divisor  = b[7:0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(a, b, tag);
  endtask

  task automatic take(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ".take_valid"}, out_valid, 0);
    check({tag, ".take_ready"}, in_ready,  1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [16:0] ra;
    logic [7:0]  rb;
    int          a;
    int          b;

    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready",  in_ready,  1);
    check("rst.out_valid", out_valid, 0);
    check("rst.busy",      busy,      0);
    check("rst.quot",      quotient,  0);
    check("rst.rem",       remainder, 0);
    check("rst.ovf",       ovf,       0);
    check("rst.dbz",       dbz,       0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(100, 7, "d_100_7");          take("d_100_7");
    issue(-100, 7, "d_m100_7");        take("d_m100_7");
    issue(65535, -128, "d_65535_m128"); take("d_65535_m128");
    issue(-65536, -1, "d_ovf");        take("d_ovf");
    issue(5, 0, "d_dbz");              take("d_dbz");
    issue(0, 9, "d_zero_dvd");         take("d_zero_dvd");
    issue(-65536, 1, "d_min_1");       take("d_min_1");
    issue(-127, -128, "d_m127_m128");  take("d_m127_m128");

    // Consumer stalls: results hold and a new request is ignored until released.
    issue(1000, -3, "hold");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 17'd77;
      divisor  = 8'd7;
      @(posedge clk); #1;
      check("hold.valid", out_valid, 1);
      check("hold.ready", in_ready,  0);
      check("hold.quot",  quotient,  {15'd0, e_q});
      check("hold.rem",   remainder, {24'd0, e_r});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold.rel_valid", out_valid, 0);
    check("hold.rel_ready", in_ready,  1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(77, 7, "hold2");
    take("hold2");

    // Reset in the middle of a calculation.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 17'd100;
    divisor  = 8'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", out_valid, 0);
    check("midrst.busy",      busy,      0);
    check("midrst.in_ready",  in_ready,  1);
    check("midrst.ovf",       ovf,       0);
    check("midrst.dbz",       dbz,       0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    issue(50, -5, "after_rst");
    take("after_rst");

    for (int i = 0; i < 60; i++) begin
      ra = 17'($urandom);
      rb = 8'($urandom);
      a  = int'($signed(ra));
      b  = int'($signed(rb));
      case ($urandom_range(0, 9))
        0: b = 0;
        1: b = -1;
        2: a = -65536;
        3: a = 0;
        4: b = -128;
        default: ;
      endcase
      issue(a, b, "rnd");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      check("rnd.stall_valid", out_valid, 1);
      take("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
